// File: rtl/ysyx_lsu.sv
// Load/store unit between EXU and WBU: one word-aligned bus request per memory op,
// returning lane-extracted load data, a pass-through ALU result, or a fault flag.
module ysyx_lsu #(
   parameter int BIT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prev_valid,
   output logic             ready_o,
   input  logic [BIT_W-1:0] pc,
   input  logic [BIT_W-1:0] inst,
   input  logic             ebreak,
   input  logic             ren,
   input  logic             wen,
   input  logic [2:0]       funct3,
   input  logic [BIT_W-1:0] alu_res,
   input  logic [BIT_W-1:0] wdata,
   input  logic             next_ready,
   output logic             valid_o,
   output logic [BIT_W-1:0] pc_o,
   output logic [BIT_W-1:0] inst_o,
   output logic             ebreak_o,
   output logic [BIT_W-1:0] rdata_o,
   output logic             fault_o,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [BIT_W-1:0] mem_addr,
   output logic [BIT_W-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_rsp_valid,
   input  logic [BIT_W-1:0] mem_rdata,
   output logic [1:0]       dbg_state_o
);

   // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
   // once valid is raised it stays high with a stable payload until that edge.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [BIT_W-1:0] pc_q, pc_d;
   logic [BIT_W-1:0] inst_q, inst_d;
   logic             ebreak_q, ebreak_d;
   logic [BIT_W-1:0] rdata_q, rdata_d;
   logic             fault_q, fault_d;
   logic [BIT_W-1:0] addr_q, addr_d;
   logic [BIT_W-1:0] wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       off_q, off_d;
   logic             is_load_q, is_load_d;

   logic [1:0]       acc_off;
   logic             acc_legal;
   logic [3:0]       acc_strb;
   logic [BIT_W-1:0] acc_wdata;
   logic [BIT_W-1:0] lane;
   logic [BIT_W-1:0] load_val;

   // Decode of the op presented in IDLE: alignment, strobes and lane-shifted data.
   always_comb begin
      acc_off   = alu_res[1:0];
      acc_legal = 1'b0;
      if (ren && !wen) begin
         case (funct3)
            3'b000, 3'b100: acc_legal = 1'b1;
            3'b001, 3'b101: acc_legal = ~alu_res[0];
            3'b010:         acc_legal = (alu_res[1:0] == 2'b00);
            default:        acc_legal = 1'b0;
         endcase
      end else if (wen && !ren) begin
         case (funct3)
            3'b000:  acc_legal = 1'b1;
            3'b001:  acc_legal = ~alu_res[0];
            3'b010:  acc_legal = (alu_res[1:0] == 2'b00);
            default: acc_legal = 1'b0;
         endcase
      end
      case (funct3[1:0])
         2'b00:   acc_strb = 4'b0001 << acc_off;
         2'b01:   acc_strb = 4'b0011 << acc_off;
         default: acc_strb = 4'b1111;
      endcase
      acc_wdata = wdata << {acc_off, 3'b000};
   end

   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b100:  load_val = {24'd0, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b101:  load_val = {16'd0, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      ebreak_d  = ebreak_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      funct3_d  = funct3_q;
      off_d     = off_q;
      is_load_d = is_load_q;
      case (state_q)
         S_IDLE: begin
            if (prev_valid) begin
               pc_d      = pc;
               inst_d    = inst;
               ebreak_d  = ebreak;
               funct3_d  = funct3;
               off_d     = acc_off;
               is_load_d = ren;
               addr_d    = {alu_res[BIT_W-1:2], 2'b00};
               wdata_d   = acc_wdata;
               wstrb_d   = 4'b0000;
               rdata_d   = '0;
               fault_d   = 1'b0;
               if (!ren && !wen) begin
                  rdata_d = alu_res;
                  state_d = S_DONE;
               end else if (!acc_legal) begin
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  wstrb_d = wen ? acc_strb : 4'b0000;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = S_RSP;
         end
         S_RSP: begin
            if (mem_rsp_valid) begin
               rdata_d = is_load_q ? load_val : '0;
               state_d = S_DONE;
            end
         end
         default: begin
            if (next_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         inst_q    <= '0;
         ebreak_q  <= 1'b0;
         rdata_q   <= '0;
         fault_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= 4'b0000;
         funct3_q  <= 3'b000;
         off_q     <= 2'b00;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         ebreak_q  <= ebreak_d;
         rdata_q   <= rdata_d;
         fault_q   <= fault_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         funct3_q  <= funct3_d;
         off_q     <= off_d;
         is_load_q <= is_load_d;
      end
   end

   assign ready_o       = (state_q == S_IDLE);
   assign valid_o       = (state_q == S_DONE);
   assign mem_req_valid = (state_q == S_REQ);
   assign pc_o          = pc_q;
   assign inst_o        = inst_q;
   assign ebreak_o      = ebreak_q;
   assign rdata_o       = rdata_q;
   assign fault_o       = fault_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign dbg_state_o   = state_q;

endmodule

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 BIT_W, 32, datapath/address width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous active-low reset (rst==0 resets on posedge clk).
REQ-004 prev_valid  in  1  EXU result valid.
REQ-005 ready_o  out  1  LSU can accept an EXU op.
REQ-006 pc  in  32  op PC.
REQ-007 inst  in  32  op instruction word.
REQ-008 ebreak  in  1  op is EBREAK.
REQ-009 ren  in  1  op is a load.
REQ-010 wen  in  1  op is a store.
REQ-011 funct3  in  3  RV32I load/store size/sign code.
REQ-012 alu_res  in  32  memory address if ren|wen, else pass-through result.
REQ-013 wdata  in  32  store data, unaligned (bits [7:0]/[15:0]/[31:0]).
REQ-014 next_ready  in  1  WBU ready.
REQ-015 valid_o  out  1  WBU-bound payload valid.
REQ-016 pc_o / inst_o / ebreak_o  out  32/32/1  registered copies of the accepted op.
REQ-017 rdata_o  out  32  writeback value: extended load data, alu_res, or 0 (store/fault).
REQ-018 fault_o  out  1  misaligned or illegal access; no bus transaction issued.
REQ-019 mem_req_valid  out  1  bus request valid.
REQ-020 mem_req_ready  in  1  bus accepts request.
REQ-021 mem_addr / mem_wdata  out  32/32  word-aligned address (addr[1:0]=0); lane-shifted store data.
REQ-022 mem_wstrb  out  4  byte strobes; 4'b0000 SHALL mean read.
REQ-023 mem_rsp_valid / mem_rdata  in  1/32  response valid (reads and writes) and read word.

Function
REQ-024 FSM states: IDLE, REQ, RSP, DONE; ready_o SHALL be 1 only in IDLE.
REQ-025 Accept = prev_valid & ready_o in IDLE: latch pc, inst, ebreak, ren, wen, funct3, alu_res, wdata.
REQ-026 Accept with ren==wen==0: IDLE->DONE, rdata_o=alu_res, fault_o=0; valid_o high the cycle after accept.
REQ-027 Accept with exactly one of ren/wen and legal alignment: IDLE->REQ; mem_req_valid=1 from the next cycle, held with stable addr/wdata/wstrb until mem_req_ready.
REQ-028 REQ & mem_req_ready -> RSP, mem_req_valid drops next cycle; RSP & mem_rsp_valid -> DONE, capture rdata_o; mem_rsp_valid in any other state SHALL be ignored.
REQ-029 Legal sizes: funct3 000/100 byte any addr; 001/101 half addr[0]==0; 010 word addr[1:0]==0; stores only 000/001/010.
REQ-030 Misaligned, illegal funct3, or ren&wen both 1: IDLE->DONE, fault_o=1, rdata_o=0, no mem_req_valid.
REQ-031 Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; wdata lane-shifted by 8*addr[1:0]; store rdata_o=0.
REQ-032 Load data: select byte/half at 8*addr[1:0] of mem_rdata; 000/001 sign-extend, 100/101 zero-extend, 010 whole word.
REQ-033 DONE: valid_o=1 with pc_o/inst_o/ebreak_o/rdata_o/fault_o stable until next_ready; on valid_o&next_ready -> IDLE, valid_o=0 next cycle.
REQ-034 Minimum latency: ALU op accept->valid_o 1 cycle; memory op with mem_req_ready and mem_rsp_valid each 1 cycle after assertion: 3 cycles.

Reset
REQ-035 On rst==0 at any state: state=IDLE, valid_o=0, ready_o=1, mem_req_valid=0, mem_wstrb=0, fault_o=0, rdata_o=0; in-flight transaction abandoned, its late response ignored.

Verification
REQ-036 ALU op alu_res=0x1234, next_ready=1 -> valid_o one cycle after accept, rdata_o=0x1234, no mem_req_valid.
REQ-037 LB addr=0x8000_0003, mem_rdata=0x80FF_FFFF -> mem_addr=0x8000_0000, wstrb=0, rdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 SH addr=0x1002 wdata=0xABCD_5678 -> mem_addr=0x1000, wstrb=4'b1100, mem_wdata[31:16]=0x5678, rdata_o=0.
REQ-039 LW addr=0x1002 -> fault_o=1, rdata_o=0, mem_req_valid never asserted, valid_o next cycle.
REQ-040 Backpressure: mem_req_ready low 3 cycles then next_ready low 2 cycles -> request fields stable, then payload stable, ready_o=0 throughout.
REQ-041 rst=0 while in RSP, then mem_rsp_valid pulse after release -> IDLE, ready_o=1, valid_o stays 0.
